// File: rtl/acia6850_pkg.sv
// Shared MC6850 ACIA definitions: status bit indices, control-register fields,
// master-reset code, control reset value and register-select encodings.
package acia6850_pkg;

  localparam int ST_RDRF = 0;
  localparam int ST_TDRE = 1;
  localparam int ST_DCD  = 2;
  localparam int ST_CTS  = 3;
  localparam int ST_FE   = 4;
  localparam int ST_OVRN = 5;
  localparam int ST_PE   = 6;
  localparam int ST_IRQ  = 7;

  localparam int CR_CDS_LSB = 0;
  localparam int CR_TC_LSB  = 5;
  localparam int CR_RIE     = 7;

  localparam logic [1:0] MR_CODE  = 2'b11;
  localparam logic [7:0] CR_RESET = 8'h03;

  localparam logic RS_STATCTRL = 1'b0;
  localparam logic RS_DATA     = 1'b1;

  typedef enum logic [1:0] {
    TC_RTS_LO = 2'b00,
    TC_TIE    = 2'b01,
    TC_RTS_HI = 2'b10,
    TC_BREAK  = 2'b11
  } tc_e;

endpackage

// File: rtl/acia6850_stream_fifo.sv
// Generic synchronous FIFO (sync_fifo): one-cycle push/pop, registered count,
// synchronous flush; push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk2MHz,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk2MHz) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk2MHz) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/acia6850_stream.sv
// MC6850 ACIA with byte-stream TX/RX FIFOs; CPU reads are combinational, writes commit at the edge.
// ACIA_RX_FLOWCTL_EN: backpressure RX when full (RX_READY low, nRTS high) instead of flagging overrun.
module acia6850_stream
  import acia6850_pkg::*;
#(
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic       clk2MHz,
  input  logic       RESET,
  input  logic       ACCESS_EN,
  input  logic       nCS,
  input  logic       RS,
  input  logic       RnW,
  input  logic [7:0] DIN,
  output logic [7:0] DOUT,
  output logic       DOE,
  output logic       nIRQ,
  output logic       nRTS,
  input  logic       nCTS,
  input  logic       nDCD,
  output logic [7:0] TX_DATA,
  output logic       TX_VALID,
  input  logic       TX_READY,
  input  logic [7:0] RX_DATA,
  input  logic       RX_VALID,
  output logic       RX_READY
);

  logic [7:0] cr;
  logic [7:0] hold;
  logic       ovrn;

  logic       acc, wr_cr, mr_write, data_wr, data_rd;
  logic       mr, tie, rie, rdrf, tdre, irq;
  logic       tx_push, tx_pop, tx_full, tx_empty;
  logic       rx_push, rx_pop, rx_full, rx_empty, rx_accept, ovrn_set;
  logic [7:0] rx_head;
  logic [7:0] status;
  logic [$clog2(TX_DEPTH):0] tx_count;
  logic [$clog2(RX_DEPTH):0] rx_count;
  logic       unused_bits;

  assign acc      = ACCESS_EN & ~nCS;
  assign wr_cr    = acc & ~RnW & (RS == RS_STATCTRL);
  assign mr_write = wr_cr & (DIN[CR_CDS_LSB +: 2] == MR_CODE);
  assign data_wr  = acc & ~RnW & (RS == RS_DATA);
  assign data_rd  = acc &  RnW & (RS == RS_DATA);

  assign mr  = (cr[CR_CDS_LSB +: 2] == MR_CODE);
  assign tie = (cr[CR_TC_LSB +: 2] == TC_TIE);
  assign rie = cr[CR_RIE];

  assign TX_VALID = ~tx_empty & ~mr & ~nCTS;
  assign tx_pop   = TX_VALID & TX_READY;
  assign tx_push  = data_wr & ~tx_full & ~mr;

`ifdef ACIA_RX_FLOWCTL_EN
  assign RX_READY = ~mr & ~rx_full;
  assign nRTS     = (cr[CR_TC_LSB +: 2] == TC_RTS_HI) | rx_full;
`else
  assign RX_READY = ~mr;
  assign nRTS     = (cr[CR_TC_LSB +: 2] == TC_RTS_HI);
`endif

  // Fullness is the pre-edge view, so a same-cycle CPU pop never makes room.
  assign rx_accept = RX_VALID & RX_READY;
  assign rx_push   = rx_accept & ~rx_full;
  assign ovrn_set  = rx_accept & rx_full;
  assign rx_pop    = data_rd & ~rx_empty;

  assign rdrf = ~rx_empty & ~mr;
  assign tdre = ~tx_full & ~nCTS & ~mr;
  assign irq  = (rie & (rdrf | ovrn | nDCD)) | (tie & tdre);
  assign nIRQ = ~irq;

  always_comb begin
    status          = 8'h00;
    status[ST_RDRF] = rdrf;
    status[ST_TDRE] = tdre;
    status[ST_DCD]  = nDCD;
    status[ST_CTS]  = nCTS;
    status[ST_FE]   = 1'b0;
    status[ST_OVRN] = ovrn;
    status[ST_PE]   = 1'b0;
    status[ST_IRQ]  = irq;
  end

  assign DOUT = (RS == RS_DATA) ? (rx_empty ? hold : rx_head) : status;
  assign DOE  = ACCESS_EN & ~nCS & RnW;

  // Flush beats any handshake in the same cycle, so MR entry wins cleanly.
  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk2MHz (clk2MHz),
    .reset   (RESET),
    .flush   (mr_write),
    .push    (tx_push),
    .wdata   (DIN),
    .pop     (tx_pop),
    .rdata   (TX_DATA),
    .full    (tx_full),
    .empty   (tx_empty),
    .count   (tx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk2MHz (clk2MHz),
    .reset   (RESET),
    .flush   (mr_write),
    .push    (rx_push),
    .wdata   (RX_DATA),
    .pop     (rx_pop),
    .rdata   (rx_head),
    .full    (rx_full),
    .empty   (rx_empty),
    .count   (rx_count)
  );

  always_ff @(posedge clk2MHz) begin
    if (RESET) begin
      cr   <= CR_RESET;
      hold <= 8'h00;
      ovrn <= 1'b0;
    end else begin
      if (wr_cr)  cr   <= DIN;
      if (rx_pop) hold <= rx_head;
      if (mr_write || data_rd) ovrn <= 1'b0;
      else if (ovrn_set)       ovrn <= 1'b1;
    end
  end

  assign unused_bits = ^{cr[4:2], tx_count, rx_count};

endmodule

// File: tb/tb_acia6850_stream.sv
// Directed self-checking bench for acia6850_stream (TX/RX depth 4); follows ACIA_RX_FLOWCTL_EN if defined.
module tb_acia6850_stream;

  logic       clk2MHz = 1'b0;
  logic       RESET = 1'b1;
  logic       ACCESS_EN = 1'b0;
  logic       nCS = 1'b1;
  logic       RS = 1'b0;
  logic       RnW = 1'b1;
  logic [7:0] DIN = 8'h00;
  logic [7:0] DOUT;
  logic       DOE;
  logic       nIRQ;
  logic       nRTS;
  logic       nCTS = 1'b0;
  logic       nDCD = 1'b0;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_READY = 1'b0;
  logic [7:0] RX_DATA = 8'h00;
  logic       RX_VALID = 1'b0;
  logic       RX_READY;

  int vecs = 0;
  int errs = 0;

  always #5 clk2MHz = ~clk2MHz;

  acia6850_stream #(.TX_DEPTH(4), .RX_DEPTH(4)) dut (
    .clk2MHz   (clk2MHz),
    .RESET     (RESET),
    .ACCESS_EN (ACCESS_EN),
    .nCS       (nCS),
    .RS        (RS),
    .RnW       (RnW),
    .DIN       (DIN),
    .DOUT      (DOUT),
    .DOE       (DOE),
    .nIRQ      (nIRQ),
    .nRTS      (nRTS),
    .nCTS      (nCTS),
    .nDCD      (nDCD),
    .TX_DATA   (TX_DATA),
    .TX_VALID  (TX_VALID),
    .TX_READY  (TX_READY),
    .RX_DATA   (RX_DATA),
    .RX_VALID  (RX_VALID),
    .RX_READY  (RX_READY)
  );

  task automatic tick();
    @(posedge clk2MHz);
    #1;
  endtask

  task automatic cpu_wr(input logic rs, input logic [7:0] d);
    ACCESS_EN = 1'b1; nCS = 1'b0; RnW = 1'b0; RS = rs; DIN = d;
    tick();
    ACCESS_EN = 1'b0; nCS = 1'b1; RnW = 1'b1;
  endtask

  task automatic cpu_rd(input logic rs, output logic [7:0] d, output logic oe);
    ACCESS_EN = 1'b1; nCS = 1'b0; RnW = 1'b1; RS = rs;
    @(negedge clk2MHz);
    d  = DOUT;
    oe = DOE;
    tick();
    ACCESS_EN = 1'b0; nCS = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic oe;
    RESET = 1'b1;
    repeat (2) tick();
    RESET = 1'b0;
    vecs++; if (TX_VALID !== 1'b0) begin errs++; $display("FAIL rst_tx_valid got %b exp 0", TX_VALID); end
    vecs++; if (RX_READY !== 1'b0) begin errs++; $display("FAIL rst_rx_ready got %b exp 0", RX_READY); end
    vecs++; if (nIRQ !== 1'b1) begin errs++; $display("FAIL rst_nirq got %b exp 1", nIRQ); end
    vecs++; if (nRTS !== 1'b0) begin errs++; $display("FAIL rst_nrts got %b exp 0", nRTS); end
    vecs++; if (DOE !== 1'b0) begin errs++; $display("FAIL rst_doe_idle got %b exp 0", DOE); end
    cpu_rd(1'b0, d, oe);
    vecs++; if (d !== 8'h00) begin errs++; $display("FAIL rst_status got %h exp 00", d); end
    vecs++; if (oe !== 1'b1) begin errs++; $display("FAIL rd_doe got %b exp 1", oe); end
    nDCD = 1'b1; nCTS = 1'b1;
    cpu_rd(1'b0, d, oe);
    vecs++; if (d !== 8'h0C) begin errs++; $display("FAIL rst_status_pins got %h exp 0c", d); end
    nDCD = 1'b0; nCTS = 1'b0;
    cpu_wr(1'b0, 8'h95);
    vecs++; if (RX_READY !== 1'b1) begin errs++; $display("FAIL cr95_rx_ready got %b exp 1", RX_READY); end
    cpu_rd(1'b0, d, oe);
    vecs++; if (d !== 8'h02) begin errs++; $display("FAIL cr95_status got %h exp 02", d); end
    vecs++; if (nIRQ !== 1'b1) begin errs++; $display("FAIL cr95_nirq got %b exp 1", nIRQ); end
    nDCD = 1'b1;
    cpu_rd(1'b0, d, oe);
    vecs++; if (d !== 8'h86) begin errs++; $display("FAIL dcd_status got %h exp 86", d); end
    vecs++; if (nIRQ !== 1'b0) begin errs++; $display("FAIL dcd_nirq got %b exp 0", nIRQ); end
    nDCD = 1'b0;
  endtask

  task automatic test_tx_fill();
    logic [7:0] d;
    logic oe;
    TX_READY = 1'b0;
    for (int i = 0; i < 3; i++) cpu_wr(1'b1, 8'h41 + 8'(i));
    cpu_rd(1'b0, d, oe);
    vecs++; if (d !== 8'h02) begin errs++; $display("FAIL tx3_status got %h exp 02", d); end
    cpu_wr(1'b1, 8'h44);
    cpu_rd(1'b0, d, oe);
    vecs++; if (d !== 8'h00) begin errs++; $display("FAIL tx4_status got %h exp 00", d); end
    cpu_wr(1'b1, 8'h45);
    vecs++; if (TX_VALID !== 1'b1 || TX_DATA !== 8'h41) begin errs++; $display("FAIL tx_head got %b/%h exp 1/41", TX_VALID, TX_DATA); end
    // Pop and write to a full FIFO in one cycle: the write must be dropped.
    TX_READY = 1'b1;
    ACCESS_EN = 1'b1; nCS = 1'b0; RnW = 1'b0; RS = 1'b1; DIN = 8'h46;
    @(negedge clk2MHz);
    vecs++; if (TX_VALID !== 1'b1 || TX_DATA !== 8'h41) begin errs++; $display("FAIL tx_drain0 got %b/%h exp 1/41", TX_VALID, TX_DATA); end
    tick();
    ACCESS_EN = 1'b0; nCS = 1'b1; RnW = 1'b1;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk2MHz);
      vecs++; if (TX_VALID !== 1'b1 || TX_DATA !== 8'h41 + 8'(i)) begin errs++; $display("FAIL tx_drain%0d got %b/%h exp 1/%h", i, TX_VALID, TX_DATA, 8'h41 + 8'(i)); end
      tick();
    end
    @(negedge clk2MHz);
    vecs++; if (TX_VALID !== 1'b0) begin errs++; $display("FAIL tx_empty got %b exp 0", TX_VALID); end
    tick();
    TX_READY = 1'b0;
  endtask

`ifdef ACIA_RX_FLOWCTL_EN
  task automatic test_rx_flowctl();
    logic [7:0] d;
    logic oe;
    logic rdy;
    int acc;
    for (int i = 0; i < 4; i++) cpu_wr(1'b1, 8'h50 + 8'(i));
    acc = 0;
    RX_VALID = 1'b1;
    for (int k = 0; k < 6; k++) begin
      RX_DATA = 8'h10 + 8'(acc);
      @(negedge clk2MHz);
      rdy = RX_READY;
      tick();
      if (rdy) acc++;
    end
    RX_VALID = 1'b0;
    vecs++; if (acc !== 4) begin errs++; $display("FAIL fc_accepted got %0d exp 4", acc); end
    vecs++; if (RX_READY !== 1'b0) begin errs++; $display("FAIL fc_rx_ready got %b exp 0", RX_READY); end
    vecs++; if (nRTS !== 1'b1) begin errs++; $display("FAIL fc_nrts got %b exp 1", nRTS); end
    cpu_rd(1'b0, d, oe);
    vecs++; if (d !== 8'h81) begin errs++; $display("FAIL fc_status got %h exp 81", d); end
    cpu_rd(1'b1, d, oe);
    vecs++; if (d !== 8'h10) begin errs++; $display("FAIL fc_read got %h exp 10", d); end
    vecs++; if (RX_READY !== 1'b1 || nRTS !== 1'b0) begin errs++; $display("FAIL fc_resume got %b/%b exp 1/0", RX_READY, nRTS); end
  endtask
`else
  task automatic test_rx_overrun();
    logic [7:0] d;
    logic oe;
    for (int i = 0; i < 4; i++) cpu_wr(1'b1, 8'h50 + 8'(i));
    RX_VALID = 1'b1;
    for (int k = 0; k < 5; k++) begin
      RX_DATA = 8'h10 + 8'(k);
      tick();
    end
    RX_VALID = 1'b0;
    cpu_rd(1'b0, d, oe);
    vecs++; if (d !== 8'hA1) begin errs++; $display("FAIL ovrn_status got %h exp a1", d); end
    vecs++; if (nIRQ !== 1'b0) begin errs++; $display("FAIL ovrn_nirq got %b exp 0", nIRQ); end
    cpu_rd(1'b1, d, oe);
    vecs++; if (d !== 8'h10) begin errs++; $display("FAIL ovrn_read got %h exp 10", d); end
    cpu_rd(1'b0, d, oe);
    vecs++; if (d !== 8'h81) begin errs++; $display("FAIL ovrn_cleared got %h exp 81", d); end
  endtask
`endif

  task automatic test_cts_gating();
    logic [7:0] d;
    logic oe;
    TX_READY = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk2MHz);
      vecs++; if (TX_VALID !== 1'b1 || TX_DATA !== 8'h50 + 8'(i)) begin errs++; $display("FAIL cts_pre%0d got %b/%h exp 1/%h", i, TX_VALID, TX_DATA, 8'h50 + 8'(i)); end
      tick();
    end
    nCTS = 1'b1;
    repeat (2) tick();
    vecs++; if (TX_VALID !== 1'b0 || TX_DATA !== 8'h52) begin errs++; $display("FAIL cts_hold got %b/%h exp 0/52", TX_VALID, TX_DATA); end
    cpu_rd(1'b0, d, oe);
    vecs++; if (d !== 8'h89) begin errs++; $display("FAIL cts_status got %h exp 89", d); end
    nCTS = 1'b0;
    for (int i = 2; i < 4; i++) begin
      @(negedge clk2MHz);
      vecs++; if (TX_VALID !== 1'b1 || TX_DATA !== 8'h50 + 8'(i)) begin errs++; $display("FAIL cts_post%0d got %b/%h exp 1/%h", i, TX_VALID, TX_DATA, 8'h50 + 8'(i)); end
      tick();
    end
    vecs++; if (TX_VALID !== 1'b0) begin errs++; $display("FAIL cts_empty got %b exp 0", TX_VALID); end
    TX_READY = 1'b0;
  endtask

  task automatic test_master_reset();
    logic [7:0] d;
    logic oe;
    cpu_wr(1'b1, 8'h60);
    cpu_wr(1'b1, 8'h61);
    vecs++; if (TX_VALID !== 1'b1 || TX_DATA !== 8'h60) begin errs++; $display("FAIL mr_pre_tx got %b/%h exp 1/60", TX_VALID, TX_DATA); end
    // Stream handshakes offered in the MR write cycle must be ignored.
    RX_VALID = 1'b1; RX_DATA = 8'hEE; TX_READY = 1'b1;
    cpu_wr(1'b0, 8'h03);
    vecs++; if (TX_VALID !== 1'b0 || RX_READY !== 1'b0) begin errs++; $display("FAIL mr_streams got %b/%b exp 0/0", TX_VALID, RX_READY); end
    repeat (2) tick();
    cpu_rd(1'b0, d, oe);
    vecs++; if (d !== 8'h00) begin errs++; $display("FAIL mr_status got %h exp 00", d); end
    cpu_rd(1'b1, d, oe);
    vecs++; if (d !== 8'h10) begin errs++; $display("FAIL mr_hold got %h exp 10", d); end
    RX_VALID = 1'b0; TX_READY = 1'b0;
    cpu_wr(1'b0, 8'h00);
    cpu_rd(1'b0, d, oe);
    vecs++; if (d !== 8'h02) begin errs++; $display("FAIL mr_exit_status got %h exp 02", d); end
    vecs++; if (TX_VALID !== 1'b0 || RX_READY !== 1'b1) begin errs++; $display("FAIL mr_exit_streams got %b/%b exp 0/1", TX_VALID, RX_READY); end
  endtask

  task automatic test_ctrl();
    cpu_wr(1'b0, 8'h40);
    vecs++; if (nRTS !== 1'b1 || nIRQ !== 1'b1) begin errs++; $display("FAIL cr40 got %b/%b exp 1/1", nRTS, nIRQ); end
    cpu_wr(1'b0, 8'h20);
    vecs++; if (nRTS !== 1'b0 || nIRQ !== 1'b0) begin errs++; $display("FAIL cr20_tie got %b/%b exp 0/0", nRTS, nIRQ); end
    cpu_wr(1'b0, 8'h60);
    vecs++; if (nRTS !== 1'b0 || nIRQ !== 1'b1) begin errs++; $display("FAIL cr60 got %b/%b exp 0/1", nRTS, nIRQ); end
  endtask

  task automatic test_reset_priority();
    logic [7:0] d;
    logic oe;
    cpu_wr(1'b0, 8'h00);
    RESET = 1'b1; RX_VALID = 1'b1; RX_DATA = 8'h77;
    ACCESS_EN = 1'b1; nCS = 1'b0; RnW = 1'b0; RS = 1'b1; DIN = 8'h77;
    tick();
    RESET = 1'b0; RX_VALID = 1'b0;
    ACCESS_EN = 1'b0; nCS = 1'b1; RnW = 1'b1;
    cpu_rd(1'b0, d, oe);
    vecs++; if (d !== 8'h00) begin errs++; $display("FAIL rstpri_status got %h exp 00", d); end
    cpu_wr(1'b0, 8'h00);
    cpu_rd(1'b0, d, oe);
    vecs++; if (d !== 8'h02 || TX_VALID !== 1'b0) begin errs++; $display("FAIL rstpri_empty got %h/%b exp 02/0", d, TX_VALID); end
  endtask

  initial begin
    test_reset();
    test_tx_fill();
`ifdef ACIA_RX_FLOWCTL_EN
    test_rx_flowctl();
`else
    test_rx_overrun();
`endif
    test_cts_gating();
    test_master_reset();
    test_ctrl();
    test_reset_priority();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/acia6850_stream.md
Name: acia6850_stream

Overview:
- Parametrised successor to the peripheral-stub mock ACIA: a register-accurate MC6850 ACIA model.
- CPU side uses the BBC &FE08/&FE09 register pair: status/control and data.
- The serial side is a byte-stream valid/ready interface, with parametrised TX and RX FIFOs, real status flags, interrupt generation and master reset.
- Sits on the 2 MHz peripheral bus. The top level muxes DOUT onto DATABUS when DOE is high.

Parameters:
- TX_DEPTH, 4: TX FIFO entries; power of two, at least 2.
- RX_DEPTH, 4: RX FIFO entries; power of two, at least 2.

Ports:
- clk2MHz  in  1  system clock; every flop uses the rising edge.
- RESET  in  1  synchronous reset, active-high.
- ACCESS_EN  in  1  one-cycle strobe qualifying a CPU bus access.
- nCS  in  1  ACIA chip select (nACIA), active-low.
- RS  in  1  register select (A0): 0 = status/control, 1 = data.
- RnW  in  1  1 = read, 0 = write.
- DIN  in  8  CPU write data.
- DOUT  out  8  CPU read data (combinational).
- DOE  out  1  ACCESS_EN & ~nCS & RnW.
- nIRQ  out  1  interrupt output, active-low.
- nRTS  out  1  request to send.
- nCTS  in  1  clear to send.
- nDCD  in  1  carrier detect.
- TX_DATA  out  8  transmit byte (TX FIFO head).
- TX_VALID  out  1  TX FIFO non-empty, not master reset, and nCTS = 0.
- TX_READY  in  1  sink accepts the byte.
- RX_DATA  in  8  received byte.
- RX_VALID  in  1  source presents a byte.
- RX_READY  out  1  block accepts the byte.

Behaviour:
- **Access rule:** a CPU access happens only in a cycle with ACCESS_EN=1 and nCS=0. Its side effects commit at that clock edge. DOUT is valid in the same cycle.
- **Control register CR (write, RS=0):**
  - CR[1:0]=11 means master reset (MR): both FIFOs flushed, OVRN cleared, TX_VALID=0, RX_READY=0.
  - CR[6:5]: 01 = TIE; 10 makes nRTS=1; all other codes make nRTS=0.
  - CR[7] = RIE.
  - CR[4:2] is stored but has no effect.
- **Reset values:**
  - RESET drives CR=8'h03 (MR active), both FIFOs empty, OVRN=0 and the data hold register 8'h00.
  - Outputs after reset: nIRQ=1, nRTS=0, TX_VALID=0, RX_READY=0, DOE=0.
  - RESET takes priority over every simultaneous access or stream handshake.
- **Status (read, RS=0):**
  - b0 RDRF = RX non-empty.
  - b1 TDRE = TX not full & ~nCTS.
  - b2 = nDCD.
  - b3 = nCTS.
  - b4 FE = 0.
  - b5 = OVRN.
  - b6 PE = 0.
  - b7 IRQ.
  - During MR: RDRF=0 and TDRE=0.
- **IRQ:** IRQ = RIE&(RDRF|OVRN|nDCD) | TIE&TDRE. nIRQ = ~IRQ, combinational from registered state.
- **Data write (RS=1):**
  - Pushes DIN into TX if it is not full and not in MR. Otherwise the byte is dropped silently.
  - Fullness is judged on the pre-edge count: a write to a full FIFO in the same cycle as a TX pop is dropped.
- **Data read (RS=1):**
  - DOUT = RX head if non-empty, else the data hold register (last byte read).
  - A read of a non-empty FIFO pops it and loads the hold register.
  - Any data read clears OVRN.
  - Reading an empty FIFO changes nothing.
- **TX stream:** pop on TX_VALID & TX_READY. TX_DATA is stable while TX_VALID=1 and not yet accepted. Raising nCTS mid-handshake drops TX_VALID; the byte is retained.
- **RX stream:**
  - Without flow control, RX_READY = ~MR.
  - A byte accepted while RX is full (pre-edge) is discarded and sets OVRN.
  - A simultaneous CPU pop does not free space that cycle.
- **FIFO counts:** wrap modulo depth; the count range is 0..DEPTH.
- **Writing CR with MR while bytes are pending:** the flush takes effect at that edge. A concurrent stream handshake in that cycle is ignored.
- **Leaving MR:** any CR write with [1:0]≠11.

Optional Feature:
- Macro: ACIA_RX_FLOWCTL_EN.
- Defined: RX_READY = ~MR & ~rx_full. The source is backpressured, so OVRN can never set. nRTS is additionally forced to 1 while rx_full.
- Undefined: RX_READY = ~MR and overrun behaviour is as in Behaviour.

Decomposition:
- Shared package holds:
  - status bit indices (RDRF, TDRE, DCD, CTS, FE, OVRN, PE, IRQ);
  - the CR field positions;
  - the MR code 2'b11;
  - the CR reset value 8'h03;
  - RS encodings.
- Natural sub-module: sync_fifo (params WIDTH, DEPTH).
  - Interface: push/pop, full/empty, synchronous flush, count.
  - Instantiated once for TX and once for RX.

Test Plan:
- **Reset/MR:**
  - RESET → status 8'h00 except b2/b3 reflecting the pins; TX_VALID=0, RX_READY=0, nIRQ=1.
  - Write CR=8'h95 → RX_READY=1 and TDRE=1.
- **TX fill/drain (TX_DEPTH=4):**
  - Write 8'h41..8'h45 with TX_READY=0 → TDRE=0 after the 4th write; 8'h45 dropped.
  - Raise TX_READY → bytes 41,42,43,44 in order, one per cycle.
- **RX overrun (macro off):**
  - Send 5 bytes with RIE=1 → 5th dropped; status=8'hA1; nIRQ=0.
  - Data read returns the 1st byte and clears OVRN.
- **RX flow control (macro on):** send 6 bytes → RX_READY=0 after 4, nRTS=1, OVRN stays 0; reading 1 byte re-asserts RX_READY.
- **CTS gating:** nCTS=1 with 2 bytes queued → TX_VALID=0, TDRE=0; nCTS=0 → resumes in order.
- **MR mid-operation:** 3 bytes queued in RX and 2 in TX, write CR=8'h03 → both empty, empty data read returns last-read hold value, no stream handshakes while in MR.
